// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers (one result bit per clock).
// Optional macro MDU_FAST_MUL_EN: single-cycle combinational multiply; divide timing unchanged.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    // acc: partial product upper half / partial remainder; low: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d;
    // opb: multiplicand / divisor magnitude
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem, div_quo;
`ifdef MDU_FAST_MUL_EN
    logic [PW-1:0]    fast_prod;
`else
    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    mul_next;
`endif
    logic [PW-1:0]    mul_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opb_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opb_q   <= opb_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opb_d   = opb_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        abs1 = (op[0] && in1[WIDTH-1]) ? -in1 : in1;
        abs2 = (op[0] && in2[WIDTH-1]) ? -in2 : in2;

        // Restoring divide step: shift in the next dividend bit, subtract if it fits
        div_shift = {acc_q, low_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ok    = ~div_trial[WIDTH];
        div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {low_q[WIDTH-2:0], div_ok};

`ifdef MDU_FAST_MUL_EN
        fast_prod = PW'(opb_q) * PW'(low_q);
        mul_res   = qneg_q ? -fast_prod : fast_prod;
`else
        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, low_q[WIDTH-1:1]};
        mul_res   = qneg_q ? -mul_next : mul_next;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    qneg_d  = op[0] & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    rneg_d  = op[0] & in1[WIDTH-1];
                    state_d = op[1] ? S_DIV : S_MUL;
                    opb_d   = op[1] ? abs2 : abs1;
                    low_d   = op[1] ? abs1 : abs2;
                end
            end
            S_MUL: begin
`ifdef MDU_FAST_MUL_EN
                hi_d    = mul_res[PW-1:WIDTH];
                lo_d    = mul_res[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
`else
                acc_d = mul_next[PW-1:WIDTH];
                low_d = mul_next[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = mul_res[PW-1:WIDTH];
                    lo_d    = mul_res[WIDTH-1:0];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DIV: begin
                acc_d = div_rem;
                low_d = div_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '0 && opb_q == '0) begin
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = rneg_q ? -div_rem : div_rem;
                    lo_d    = qneg_q ? -div_quo : div_quo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
